mem_stage: RTL

Memory-access pipeline stage directly downstream of the execute stage. It takes the EX/ME-registered ALU result as the effective address, runs load/store transactions on the data-memory bus through a valid/ready handshake, and stalls the pipeline while a transaction is outstanding. It aligns and extends load data and registers the ME/WB result (rd data, rd address, write enable) for writeback and for the forwarding path back to execute.

---
 rtl/mem_stage_pkg.sv | 43 ++++
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_load_align.sv | 31 +++
 rtl/mem_stage.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package mem_stage_pkg;

   localparam int REG_BUS = 64;

   // funct3 size codes; bit 2 selects zero-extension for loads
   localparam logic [2:0] MEM_LB  = 3'b000;
   localparam logic [2:0] MEM_LH  = 3'b001;
   localparam logic [2:0] MEM_LW  = 3'b010;
   localparam logic [2:0] MEM_LD  = 3'b011;
   localparam logic [2:0] MEM_LBU = 3'b100;
   localparam logic [2:0] MEM_LHU = 3'b101;
   localparam logic [2:0] MEM_LWU = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Natural alignment check on the low address bits; sz = funct3[1:0]
   function automatic logic addr_aligned(input logic [1:0] sz, input logic [2:0] a);
      case (sz)
         2'b00:   return 1'b1;
         2'b01:   return ~a[0];
         2'b10:   return (a[1:0] == 2'b00);
         default: return (a == 3'b000);
      endcase
   endfunction

   // Byte enables for a store of size sz placed at byte lane s
   function automatic logic [7:0] store_mask(input logic [1:0] sz, input logic [2:0] s);
      case (sz)
         2'b00:   return 8'h01 << s;
         2'b01:   return 8'h03 << s;
         2'b10:   return 8'h0F << s;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request bus between the ME stage (master) and memory (slave).
// Latency: n/a (signal bundle only).
// Backpressure: master holds request fields stable while dmem_valid=1 until dmem_ready.
// Signals: dmem_valid/dmem_ready handshake, dmem_addr (doubleword aligned), dmem_wen,
//          dmem_wdata/dmem_wmask store lanes, dmem_rdata load doubleword (valid with ready).
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic               dmem_valid;
   logic               dmem_ready;
   logic [REG_BUS-1:0] dmem_addr;
   logic               dmem_wen;
   logic [REG_BUS-1:0] dmem_wdata;
   logic [7:0]         dmem_wmask;
   logic [REG_BUS-1:0] dmem_rdata;

   modport master (
      output dmem_valid, dmem_addr, dmem_wen, dmem_wdata, dmem_wmask,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_valid, dmem_addr, dmem_wen, dmem_wdata, dmem_wmask,
      output dmem_ready, dmem_rdata
   );

endinterface

// File: rtl/mem_load_align.sv
// Shifts the load doubleword down to the addressed byte and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: i_rdata load doubleword, i_off byte offset addr[2:0], i_op funct3, o_data result.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [REG_BUS-1:0] i_rdata,
   input  logic [2:0]         i_off,
   input  logic [2:0]         i_op,
   output logic [REG_BUS-1:0] o_data
);

   logic [REG_BUS-1:0] w_shifted;

   assign w_shifted = i_rdata >> {i_off, 3'b000};

   always_comb begin
      o_data = w_shifted;
      case (i_op)
         MEM_LB:  o_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
         MEM_LH:  o_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
         MEM_LW:  o_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
         MEM_LBU: o_data = {56'd0, w_shifted[7:0]};
         MEM_LHU: o_data = {48'd0, w_shifted[15:0]};
         MEM_LWU: o_data = {32'd0, w_shifted[31:0]};
         default: o_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// ME pipeline stage: issues load/store on the dmem bus, aligns load data, registers ME/WB.
// Latency: non-memory op 1 cycle; memory op IDLE+REQ(>=1)+DONE, wb valid the cycle after DONE.
// Backpressure: stall_req freezes upstream while the access is issued and outstanding.
// Ports: clk/rst (async active-low), me_* instruction in ME, dmem bus master,
//        stall_req/misalign status, wb_* registered ME/WB result.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               me_valid,
   input  logic               me_mem_read,
   input  logic               me_mem_write,
   input  logic [2:0]         me_mem_op,
   input  logic [REG_BUS-1:0] me_alu_result,
   input  logic [REG_BUS-1:0] me_rs2_data,
   input  logic               me_rd_wen,
   input  logic [4:0]         me_rd_addr,
   mem_stage_if.master        dmem,
   output logic               stall_req,
   output logic               misalign,
   output logic               wb_valid,
   output logic               wb_rd_wen,
   output logic [4:0]         wb_rd_addr,
   output logic [REG_BUS-1:0] wb_rd_data
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_is_mem;
   logic               w_aligned;
   logic               w_start;
   logic [5:0]         w_shamt;
   logic [REG_BUS-1:0] w_load_data;

   logic [REG_BUS-1:0] r_addr;
   logic [REG_BUS-1:0] r_wdata;
   logic [7:0]         r_wmask;
   logic               r_wen;
   logic [2:0]         r_op;
   logic [2:0]         r_off;
   logic [REG_BUS-1:0] r_load_q;

   assign w_is_mem  = me_mem_read | me_mem_write;
   assign w_aligned = addr_aligned(me_mem_op[1:0], me_alu_result[2:0]);
   assign w_shamt   = {me_alu_result[2:0], 3'b000};

   // Next state and combinational outputs
   always_comb begin
      w_state_nxt     = r_state;
      w_start         = 1'b0;
      stall_req       = 1'b0;
      misalign        = 1'b0;
      dmem.dmem_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (me_valid && w_is_mem) begin
               if (w_aligned) begin
                  w_start     = 1'b1;
                  stall_req   = 1'b1;
                  w_state_nxt = ST_REQ;
               end else begin
                  // retires as a bubble through the normal ME/WB update
                  misalign    = 1'b1;
               end
            end
         end
         ST_REQ: begin
            dmem.dmem_valid = 1'b1;
            stall_req       = 1'b1;
            if (dmem.dmem_ready) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            // ME inputs still hold the finished access; it retires this cycle
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   mem_load_align u_load_align (
      .i_rdata (dmem.dmem_rdata),
      .i_off   (r_off),
      .i_op    (r_op),
      .o_data  (w_load_data)
   );

   // Request fields are captured once at issue so they stay stable while waiting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wmask  <= '0;
         r_wen    <= 1'b0;
         r_op     <= '0;
         r_off    <= '0;
         r_load_q <= '0;
      end else begin
         if (w_start) begin
            r_addr  <= {me_alu_result[REG_BUS-1:3], 3'b000};
            r_wdata <= me_rs2_data << w_shamt;
            r_wmask <= store_mask(me_mem_op[1:0], me_alu_result[2:0]);
            r_wen   <= me_mem_write;
            r_op    <= me_mem_op;
            r_off   <= me_alu_result[2:0];
         end
         if (r_state == ST_REQ && dmem.dmem_ready) begin
            r_load_q <= w_load_data;
         end
      end
   end

   assign dmem.dmem_addr  = r_addr;
   assign dmem.dmem_wdata = r_wdata;
   assign dmem.dmem_wmask = r_wmask;
   assign dmem.dmem_wen   = r_wen;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_valid   <= 1'b0;
         wb_rd_wen  <= 1'b0;
         wb_rd_addr <= '0;
         wb_rd_data <= '0;
      end else if (!stall_req) begin
         wb_valid   <= me_valid;
         wb_rd_wen  <= me_rd_wen & me_valid & ~misalign;
         wb_rd_addr <= me_rd_addr;
         wb_rd_data <= (r_state == ST_DONE && me_mem_read) ? r_load_q : me_alu_result;
      end
   end

endmodule
